// File: rtl/load_ext_ctrl_pkg.sv
// Shared definitions for the load sequencer: op encodings, FSM states,
// data width and the legality/alignment helpers used when a load is accepted.
package load_ext_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4
  } load_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Codes 5..7 have no meaning and are rejected at accept time.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_LW);
  endfunction

  // Bytes are always aligned; halfwords need an even address, words a multiple of 4.
  function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] off);
    logic ok;
    case (op)
      OP_LH, OP_LHU: ok = (off[0] == 1'b0);
      OP_LW:         ok = (off == 2'b00);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_ext_ctrl_if.sv
// Word-wide data-memory read port with a req/ack handshake.
// The load controller is the master; the memory is the slave.
interface load_ext_ctrl_if;
  import load_ext_ctrl_pkg::*;

  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/load_ext_ctrl_extend.sv
// Combinational byte/halfword select and zero/sign extension of a
// little-endian memory word according to the load op and byte offset.
module load_extend
  import load_ext_ctrl_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [1:0]        off_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword, then extend according to the op.
  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    case (op_i)
      OP_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result_o = {24'b0, byte_sel};
      OP_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result_o = {16'b0, half_sel};
      OP_LW:   result_o = word_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/load_ext_ctrl.sv
// Load sequencer: accepts one load in IDLE, issues a word read, waits for
// ack (or times out), extends the returned data and reports it with a
// one-cycle done pulse. Illegal ops and misaligned addresses skip the bus.
module load_ext_ctrl
  import load_ext_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] addr,
  load_ext_ctrl_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rdata,
  output logic              err
);

  state_e            state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;

  logic              accept_ok;
  logic              last_wait;
  logic [WORD_W-1:0] ext_word;

  assign accept_ok = op_legal(op) && op_aligned(op, addr[1:0]);
  assign last_wait = (cnt_q == CNT_W'(TIMEOUT - 1));

  load_extend u_extend (
    .op_i     (op_q),
    .off_i    (off_q),
    .word_i   (mem.mem_rdata),
    .result_o (ext_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an ack in the last wait cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = accept_ok ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack || last_wait) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched load context.
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    op_d       = op_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        cnt_d     = '0;
        if (start) begin
          if (accept_ok) begin
            op_d       = op;
            off_d      = addr[1:0];
            mem_addr_d = {addr[WORD_W-1:2], 2'b00};
            mem_req_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          rdata_d   = ext_word;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end else if (last_wait) begin
          err_d     = 1'b1;
          rdata_d   = '0;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        mem_req_d = 1'b0;
        cnt_d     = '0;
      end
      default: begin
        mem_req_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // Output and context registers; reset discards any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      op_q       <= 3'd0;
      off_q      <= 2'd0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      off_q      <= off_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed bench for load_ext_ctrl with a cycle-stepped memory responder.
module tb_load_ext_ctrl;
  import load_ext_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  int n_cmp;
  int n_mis;

  load_ext_ctrl_if mem_if ();

  load_ext_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .addr  (addr),
    .mem   (mem_if),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one load and step the memory side cycle by cycle.
  // ack_wait < 0 means the memory never acknowledges.
  // With inject set, a conflicting start is pulsed in the second REQ cycle.
  task automatic run_load(input logic [2:0] o, input logic [31:0] a,
                          input int ack_wait, input logic [31:0] word,
                          input bit inject,
                          output int req_cycles, output int lat,
                          output logic [31:0] rd, output logic e,
                          output int addr_bad);
    logic [31:0] exp_maddr;
    exp_maddr  = {a[31:2], 2'b00};
    req_cycles = 0;
    lat        = -1;
    rd         = '0;
    e          = 1'b0;
    addr_bad   = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; addr = a;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      mem_if.mem_ack = 1'b0;
      if (inject && n == 2) begin
        start = 1'b1; op = OP_LW; addr = 32'h0000_7770;
      end else begin
        start = 1'b0;
      end
      if (mem_if.mem_req) begin
        req_cycles++;
        if (mem_if.mem_addr !== exp_maddr) addr_bad++;
        if (ack_wait >= 0 && req_cycles - 1 == ack_wait) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = word;
        end
      end
      if (done) begin
        lat = n;
        rd  = rdata;
        e   = err;
        break;
      end
      @(posedge clk); #1;
    end
    start          = 1'b0;
    mem_if.mem_ack = 1'b0;
  endtask

  int          rq, lt, ab;
  logic [31:0] rd;
  logic        e;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    addr  = '0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    {31'b0, busy}, 32'h0);
    chk("rst_done",    {31'b0, done}, 32'h0);
    chk("rst_err",     {31'b0, err}, 32'h0);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_mem_req", {31'b0, mem_if.mem_req}, 32'h0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LB, offset 3, zero wait
    run_load(OP_LB, 32'h0000_1003, 0, 32'h80FF_0102, 1'b0, rq, lt, rd, e, ab);
    chk("lb_lat",   lt, 2);
    chk("lb_req",   rq, 1);
    chk("lb_addr",  ab, 0);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    chk("lb_err",   {31'b0, e}, 32'h0);

    // LHU, upper half, 3 wait cycles
    run_load(OP_LHU, 32'h0000_2002, 3, 32'h9ABC_1234, 1'b0, rq, lt, rd, e, ab);
    chk("lhu_lat",   lt, 5);
    chk("lhu_req",   rq, 4);
    chk("lhu_addr",  ab, 0);
    chk("lhu_rdata", rd, 32'h0000_9ABC);

    // LH, same data
    run_load(OP_LH, 32'h0000_2002, 3, 32'h9ABC_1234, 1'b0, rq, lt, rd, e, ab);
    chk("lh_rdata", rd, 32'hFFFF_9ABC);
    chk("lh_err",   {31'b0, e}, 32'h0);

    // LH lower half, positive
    run_load(OP_LH, 32'h0000_2000, 1, 32'h9ABC_1234, 1'b0, rq, lt, rd, e, ab);
    chk("lh_lo_rdata", rd, 32'h0000_1234);

    // LBU offset 1 and LW pass-through
    run_load(OP_LBU, 32'h0000_1001, 0, 32'h80FF_C302, 1'b0, rq, lt, rd, e, ab);
    chk("lbu_rdata", rd, 32'h0000_00C3);
    run_load(OP_LW, 32'h0000_3000, 0, 32'hDEAD_BEEF, 1'b0, rq, lt, rd, e, ab);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);

    // Misaligned LW: no request, error in one cycle
    run_load(OP_LW, 32'h0000_3001, 0, 32'hDEAD_BEEF, 1'b0, rq, lt, rd, e, ab);
    chk("mis_lat",   lt, 1);
    chk("mis_req",   rq, 0);
    chk("mis_err",   {31'b0, e}, 32'h1);
    chk("mis_rdata", rd, 32'h0);

    // Misaligned LH
    run_load(OP_LW, 32'h0000_3000, 0, 32'h1111_2222, 1'b0, rq, lt, rd, e, ab);
    run_load(OP_LH, 32'h0000_2001, 0, 32'h1111_2222, 1'b0, rq, lt, rd, e, ab);
    chk("mish_err",   {31'b0, e}, 32'h1);
    chk("mish_rdata", rd, 32'h0);

    // Illegal op with aligned address
    run_load(3'd6, 32'h0000_3000, 0, 32'hDEAD_BEEF, 1'b0, rq, lt, rd, e, ab);
    chk("ill_lat", lt, 1);
    chk("ill_req", rq, 0);
    chk("ill_err", {31'b0, e}, 32'h1);

    // Timeout: preload nonzero rdata first
    run_load(OP_LW, 32'h0000_3000, 0, 32'h5555_AAAA, 1'b0, rq, lt, rd, e, ab);
    run_load(OP_LW, 32'h0000_4000, -1, 32'h0, 1'b0, rq, lt, rd, e, ab);
    chk("to_req",   rq, 16);
    chk("to_lat",   lt, 17);
    chk("to_err",   {31'b0, e}, 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_busy_at_done", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("to_busy_after", {31'b0, busy}, 32'h0);
    chk("to_done_after", {31'b0, done}, 32'h0);

    // Start pulsed during REQ must be ignored
    run_load(OP_LBU, 32'h0000_6001, 3, 32'h1122_3344, 1'b1, rq, lt, rd, e, ab);
    chk("inj_rdata", rd, 32'h0000_0033);
    chk("inj_req",   rq, 4);
    chk("inj_addr",  ab, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("inj_idle_busy", {31'b0, busy}, 32'h0);
    chk("inj_idle_req",  {31'b0, mem_if.mem_req}, 32'h0);

    // Asynchronous reset while in REQ
    @(posedge clk); #1;
    start = 1'b1; op = OP_LW; addr = 32'h0000_4000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_req", {31'b0, mem_if.mem_req}, 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req",  {31'b0, mem_if.mem_req}, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (done) seen_done++;
      end
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (done) seen_done++;
      end
      chk("arst_no_done", seen_done, 0);
    end

    run_load(OP_LBU, 32'h0000_5000, 0, 32'h0000_00AB, 1'b0, rq, lt, rd, e, ab);
    chk("post_rst_lat",   lt, 2);
    chk("post_rst_rdata", rd, 32'h0000_00AB);
    chk("post_rst_err",   {31'b0, e}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/load_ext_ctrl.md
Name: load_ext_ctrl

Overview:
- Sequences one load instruction (lb, lbu, lh, lhu, lw) against a word-wide data-memory port with a req/ack handshake, then selects, aligns and zero- or sign-extends the returned byte or halfword to 32 bits.
- Sits between the MEM-stage control and data memory.
- Stalls the pipeline via `busy` while a load is outstanding.
- Reports misaligned addresses, illegal op codes and bus timeouts on `err`.

Parameters:
- TIMEOUT, 16: cycles `mem_req` may stay high without `mem_ack` before the load aborts with `err`; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- op  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; 5..7 are illegal.
- addr  in  32  byte address; sampled together with `start`.
- mem_req  out  1  memory read request; held high until ack or timeout.
- mem_addr  out  32  word address `{addr[31:2],2'b00}`; stable while `mem_req` is high.
- mem_ack  in  1  memory has valid `mem_rdata` this cycle.
- mem_rdata  in  32  read word; little-endian (byte 0 = bits [7:0]).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; `rdata` and `err` are valid in that cycle.
- rdata  out  32  extended load result; 0 when `err` is high.
- err  out  1  valid with `done`: misaligned address, illegal op, or timeout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. `mem_req`, `busy`, `done`, `err` = 0. `rdata` = 0, `mem_addr` = 0, counter = 0. Asserting reset mid-transaction drops `mem_req` immediately and discards the load; no `done` pulse.
- States: IDLE, REQ, RESP. All outputs are registered.
- IDLE, start=1 with legal op and aligned address:
  - Latch op and `addr[1:0]`.
  - Drive `mem_addr`.
  - Next state REQ with `mem_req`=1 from the next cycle.
- Alignment rules: LH/LHU need `addr[0]`=0; LW needs `addr[1:0]`=0; LB/LBU are always aligned.
- IDLE, start=1 with illegal op or misaligned address:
  - Go to RESP with `err`=1 and `rdata`=0.
  - No memory request is issued.
- REQ, mem_ack=1:
  - Capture the extended result into `rdata`.
  - Drop `mem_req` the next cycle.
  - Go to RESP with `err`=0.
  - `mem_ack` outside REQ is ignored.
- REQ, mem_ack=0:
  - Counter increments each cycle.
  - When the counter reaches TIMEOUT-1 without ack: go to RESP with `err`=1, `rdata`=0, and drop `mem_req`.
  - An ack in that same final cycle wins: normal completion.
- RESP: `done`=1 for exactly one cycle, then IDLE. The counter clears.
- Latency:
  - Normal load: `start` at cycle T; `mem_req` high at T+1; ack at T+1+k; `done` at T+2+k. Zero-wait memory gives `done` at T+2.
  - Error path: `done` at T+1.
- `start` while `busy` is ignored (not queued). A new `start` is accepted in the cycle `done` is high? No: the FSM is in RESP that cycle, so the earliest new accept is the following IDLE cycle.
- Extension rules (`a` = latched `addr[1:0]`):
  - Byte select: `b = mem_rdata[8a+7 : 8a]`.
  - Halfword select: `h = a[1] ? mem_rdata[31:16] : mem_rdata[15:0]`.
  - LB: `{{24{b[7]}}, b}`. LBU: `{24'b0, b}`.
  - LH: `{{16{h[15]}}, h}`. LHU: `{16'b0, h}`.
  - LW: `mem_rdata` unchanged.
- `rdata` holds its value between `done` pulses.

Decomposition:
- Shared package:
  - Load op encodings LB..LW.
  - State enum IDLE/REQ/RESP.
  - Constant WORD_W=32.
- One natural sub-module: `load_extend`, purely combinational.
  - Inputs: op, offset (2 bits), word.
  - Output: the 32-bit extended result.
  - The FSM instantiates it and registers its output on ack.

Test Plan:
- LB, addr=0x1003, zero-wait memory, mem_rdata=0x80FF_0102 -> mem_addr=0x1000; done at T+2; rdata=0xFFFF_FF80; err=0.
- LHU, addr=0x2002, ack after 3 wait cycles, mem_rdata=0x9ABC_1234 -> mem_req high 4 cycles; rdata=0x0000_9ABC. Same data with LH -> rdata=0xFFFF_9ABC.
- LW, addr=0x3001 -> no mem_req; done at T+1; err=1; rdata=0. Op=6 with an aligned address -> same response.
- LW, addr=0x4000, mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles; then done with err=1 and rdata=0; busy drops the cycle after done.
- start pulsed during REQ with different op/addr -> ignored; first load completes with its original op; mem_addr unchanged throughout.
- rst_n driven low while in REQ -> mem_req and busy fall asynchronously; no done pulse. After release, an LBU addr=0x5000 with rdata=0x0000_00AB -> rdata=0x0000_00AB.
